// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator for the pipelined MIPS core.
//
// Chooses the next fetch PC, highest priority first: exception entry,
// exception return, resolved redirect, return-address-stack prediction,
// stall hold, sequential +4. It also keeps the exception PC and a small
// circular RAS that predicts `jr $ra` targets.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   stall             hold the PC
//   redirect_valid/pc branch or jump resolved in decode
//   exc_req/exc_epc   exception entry; exc_epc is captured into epc
//   eret_req          return from exception (pc <= epc)
//   ras_push/addr     call in decode; push the return address
//   ras_pop           `jr $ra` in decode; request a prediction
//   pc, epc           registered fetch PC and exception PC
//   ras_hit           combinational; the RAS top is the next PC this cycle
//   ras_count/full/empty  RAS occupancy, decoded from the registered count
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_PC    = 32'h0000_4180,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [WIDTH-1:0]             redirect_pc,
    input  logic                         exc_req,
    input  logic [WIDTH-1:0]             exc_epc,
    input  logic                         eret_req,
    input  logic                         ras_push,
    input  logic [WIDTH-1:0]             ras_push_addr,
    input  logic                         ras_pop,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             epc,
    output logic                         ras_hit,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]    tp_r;
    logic [CW-1:0]    count_r;

    logic [PW-1:0]    top_idx_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             ras_hit_s;
    logic [WIDTH-1:0] next_raw_s;
    logic [WIDTH-1:0] next_pc_s;
    logic             ras_flush_s;
    logic             ras_upd_s;
    logic             ras_we_s;
    logic [PW-1:0]    ras_waddr_s;

    // Top of stack sits one below the pointer; PW-bit arithmetic wraps modulo depth.
    assign top_idx_s = tp_r - PW'(1'b1);
    assign ras_top_s = ras_mem_r[top_idx_s];

    assign ras_empty = (count_r == {CW{1'b0}});
    assign ras_full  = (count_r == CW'(RAS_DEPTH));
    assign ras_count = count_r;

    // A prediction is used only when nothing of higher priority claims the PC.
    assign ras_hit_s = ras_pop & ~ras_empty & ~exc_req & ~eret_req & ~redirect_valid;
    assign ras_hit   = ras_hit_s;

    // Next-PC priority mux.
    always_comb begin
        next_raw_s = pc + WIDTH'(3'd4);
        if (exc_req) begin
            next_raw_s = EXC_PC;
        end else if (eret_req) begin
            next_raw_s = epc;
        end else if (redirect_valid) begin
            next_raw_s = redirect_pc;
        end else if (ras_hit_s) begin
            next_raw_s = ras_top_s;
        end else if (stall) begin
            next_raw_s = pc;
        end else begin
            next_raw_s = pc + WIDTH'(3'd4);
        end
    end

    assign next_pc_s = {next_raw_s[WIDTH-1:2], 2'b00};

    // RAS gating: exceptions flush it; a stall that nothing overrides freezes it.
    always_comb begin
        ras_flush_s = exc_req | eret_req;
        ras_upd_s   = 1'b0;
        if (ras_flush_s) begin
            ras_upd_s = 1'b0;
        end else if (stall & ~redirect_valid & ~ras_hit_s) begin
            ras_upd_s = 1'b0;
        end else begin
            ras_upd_s = 1'b1;
        end
    end

    // Push with a simultaneous hit replaces the top in place instead of growing.
    assign ras_we_s    = ras_upd_s & ras_push;
    assign ras_waddr_s = ras_hit_s ? top_idx_s : tp_r;

    // RAS storage; contents are don't-care after reset so no reset branch.
    always_ff @(posedge clk) begin
        if (ras_we_s) begin
            ras_mem_r[ras_waddr_s] <= ras_push_addr;
        end
    end

    // PC, EPC, and RAS pointer/counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            epc     <= {WIDTH{1'b0}};
            tp_r    <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            pc <= next_pc_s;
            if (exc_req) begin
                epc <= {exc_epc[WIDTH-1:2], 2'b00};
            end else begin
                epc <= epc;
            end
            if (ras_flush_s) begin
                tp_r    <= tp_r;
                count_r <= {CW{1'b0}};
            end else if (ras_upd_s) begin
                case ({ras_push, ras_hit_s})
                    2'b10: begin
                        // Full push overwrites the oldest entry; count saturates.
                        tp_r    <= tp_r + PW'(1'b1);
                        count_r <= ras_full ? count_r : count_r + CW'(1'b1);
                    end
                    2'b01: begin
                        tp_r    <= top_idx_s;
                        count_r <= count_r - CW'(1'b1);
                    end
                    default: begin
                        tp_r    <= tp_r;
                        count_r <= count_r;
                    end
                endcase
            end else begin
                tp_r    <= tp_r;
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a table of hand-computed vectors applied in
// order, expected registered results queued at drive time and compared after
// the edge, plus a hand-written asynchronous-reset sequence.
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic [31:0] exc_epc;
    logic        eret_req;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        ras_hit;
    logic [2:0]  ras_count;
    logic        ras_full;
    logic        ras_empty;

    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .exc_epc        (exc_epc),
        .eret_req       (eret_req),
        .ras_push       (ras_push),
        .ras_push_addr  (ras_push_addr),
        .ras_pop        (ras_pop),
        .pc             (pc),
        .epc            (epc),
        .ras_hit        (ras_hit),
        .ras_count      (ras_count),
        .ras_full       (ras_full),
        .ras_empty      (ras_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic        ex;
        logic [31:0] eepc;
        logic        er;
        logic        pu;
        logic [31:0] pa;
        logic        po;
        logic        hit;
        logic [31:0] xpc;
        logic [31:0] xepc;
        int          xcnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        int          cnt;
        int          idx;
    } exp_t;

    vec_t vecs [33];
    exp_t sb [$];

    function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                                input logic ex, input logic [31:0] eepc, input logic er,
                                input logic pu, input logic [31:0] pa, input logic po,
                                input logic hit, input logic [31:0] xpc,
                                input logic [31:0] xepc, input int xcnt);
        vec_t v;
        v.st = st; v.rv = rv; v.rpc = rpc; v.ex = ex; v.eepc = eepc; v.er = er;
        v.pu = pu; v.pa = pa; v.po = po; v.hit = hit; v.xpc = xpc; v.xepc = xepc;
        v.xcnt = xcnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic idle();
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        exc_req = 1'b0; exc_epc = 32'h0; eret_req = 1'b0;
        ras_push = 1'b0; ras_push_addr = 32'h0; ras_pop = 1'b0;
    endtask

    initial begin
        exp_t e;
        // st rv rpc          ex eepc         er pu pa           po hit xpc          xepc         cnt
        vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    0, 0, 32'h3004,     32'h0,    0);
        vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    0, 0, 32'h3008,     32'h0,    0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    0, 0, 32'h300C,     32'h0,    0);
        vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    0, 0, 32'h3010,     32'h0,    0);
        vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    0, 0, 32'h3010,     32'h0,    0);
        vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    0, 0, 32'h3010,     32'h0,    0);
        vecs[6]  = mk(1, 1, 32'h3102,     0, 32'h0,      0, 0, 32'h0,    0, 0, 32'h3100,     32'h0,    0);
        vecs[7]  = mk(0, 0, 32'h0,        1, 32'h3020,   0, 0, 32'h0,    0, 0, 32'h4180,     32'h3020, 0);
        vecs[8]  = mk(0, 0, 32'h0,        1, 32'h3022,   1, 0, 32'h0,    0, 0, 32'h4180,     32'h3020, 0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,      1, 0, 32'h0,    0, 0, 32'h3020,     32'h3020, 0);
        vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'h3100, 0, 0, 32'h3024,     32'h3020, 1);
        vecs[11] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'h3200, 0, 0, 32'h3028,     32'h3020, 2);
        vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'h3300, 0, 0, 32'h302C,     32'h3020, 3);
        vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'h3400, 0, 0, 32'h3030,     32'h3020, 4);
        vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'h3500, 0, 0, 32'h3034,     32'h3020, 4);
        vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    1, 1, 32'h3500,     32'h3020, 3);
        vecs[16] = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    1, 1, 32'h3400,     32'h3020, 2);
        vecs[17] = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    1, 1, 32'h3300,     32'h3020, 1);
        vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    1, 1, 32'h3200,     32'h3020, 0);
        vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    1, 0, 32'h3204,     32'h3020, 0);
        vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'h3100, 0, 0, 32'h3208,     32'h3020, 1);
        vecs[21] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'h3200, 0, 0, 32'h320C,     32'h3020, 2);
        vecs[22] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'h3800, 1, 1, 32'h3200,     32'h3020, 2);
        vecs[23] = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    1, 1, 32'h3800,     32'h3020, 1);
        vecs[24] = mk(0, 1, 32'h5000,     0, 32'h0,      0, 0, 32'h0,    1, 0, 32'h5000,     32'h3020, 1);
        vecs[25] = mk(0, 1, 32'h7000,     0, 32'h0,      0, 1, 32'h6000, 1, 0, 32'h7000,     32'h3020, 2);
        vecs[26] = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    1, 1, 32'h6000,     32'h3020, 1);
        vecs[27] = mk(1, 0, 32'h0,        0, 32'h0,      0, 1, 32'h9000, 0, 0, 32'h6000,     32'h3020, 1);
        vecs[28] = mk(1, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    1, 1, 32'h3100,     32'h3020, 0);
        vecs[29] = mk(0, 0, 32'h0,        0, 32'h0,      0, 1, 32'hA000, 0, 0, 32'h3104,     32'h3020, 1);
        vecs[30] = mk(0, 0, 32'h0,        1, 32'h3104,   0, 1, 32'hB000, 0, 0, 32'h4180,     32'h3104, 0);
        vecs[31] = mk(0, 1, 32'hFFFFFFFF, 0, 32'h0,      0, 0, 32'h0,    0, 0, 32'hFFFFFFFC, 32'h3104, 0);
        vecs[32] = mk(0, 0, 32'h0,        0, 32'h0,      0, 0, 32'h0,    0, 0, 32'h0,        32'h3104, 0);

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_pc", pc, 32'h3000);
        check("reset_epc", epc, 32'h0);
        check("reset_empty", {31'b0, ras_empty}, 32'h1);
        check("reset_count", {29'b0, ras_count}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 33; i++) begin
            stall = vecs[i].st; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
            exc_req = vecs[i].ex; exc_epc = vecs[i].eepc; eret_req = vecs[i].er;
            ras_push = vecs[i].pu; ras_push_addr = vecs[i].pa; ras_pop = vecs[i].po;
            #1;
            check($sformatf("hit[%0d]", i), {31'b0, ras_hit}, {31'b0, vecs[i].hit});
            e.pc = vecs[i].xpc; e.epc = vecs[i].xepc; e.cnt = vecs[i].xcnt; e.idx = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: got empty queue, expected one entry");
            end else begin
                e = sb.pop_front();
                check($sformatf("pc[%0d]", e.idx), pc, e.pc);
                check($sformatf("epc[%0d]", e.idx), epc, e.epc);
                check($sformatf("count[%0d]", e.idx), {29'b0, ras_count}, e.cnt);
                check($sformatf("full[%0d]", e.idx), {31'b0, ras_full}, {31'b0, (e.cnt == 4)});
                check($sformatf("empty[%0d]", e.idx), {31'b0, ras_empty}, {31'b0, (e.cnt == 0)});
            end
            @(negedge clk);
        end

        // Build up some RAS state, then reset between edges.
        idle();
        ras_push = 1'b1; ras_push_addr = 32'h1234;
        @(posedge clk);
        #3;
        check("pre_async_pc", pc, 32'h4);
        reset = 1'b1;
        #1;
        check("async_pc", pc, 32'h3000);
        check("async_epc", epc, 32'h0);
        check("async_count", {29'b0, ras_count}, 32'h0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_pc", pc, 32'h3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined MIPS core. It holds the fetch PC and chooses the next one from these sources, highest priority first:

- exception entry
- exception return
- resolved branch or jump redirect
- return-address-stack (RAS) prediction
- stall hold
- sequential increment

It also keeps the exception PC (EPC) and a small circular RAS that predicts `jr $ra` targets from the decode stage.

## Interface
Parameters:
- WIDTH, 32, PC and address width (must be ≥ 3).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception handler entry address.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥ 2).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hold the PC (fetch/decode bubble).
- redirect_valid  in  1  branch/jump resolved in decode; take redirect_pc.
- redirect_pc  in  WIDTH  redirect target.
- exc_req  in  1  exception taken this cycle.
- exc_epc  in  WIDTH  PC of the faulting instruction, captured into EPC.
- eret_req  in  1  return from exception.
- ras_push  in  1  call (jal/jalr) in decode; push ras_push_addr.
- ras_push_addr  in  WIDTH  return address to push (call PC + 8).
- ras_pop  in  1  `jr $ra` in decode; request a RAS prediction.
- pc  out  WIDTH  current fetch PC (registered).
- epc  out  WIDTH  saved exception PC (registered).
- ras_hit  out  1  combinational; the RAS prediction is selected as next PC this cycle.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_empty  out  1  ras_count == 0.

## Operation
- Next-PC selection, highest priority first:
  1. exc_req → EXC_PC.
  2. eret_req → epc.
  3. redirect_valid → redirect_pc.
  4. ras_pop and !ras_empty → RAS top.
  5. stall → pc (hold).
  6. Otherwise → pc + 4.
- Sources 1–4 override stall.
- All next-PC values have bits [1:0] forced to 0.
- The increment wraps modulo 2^WIDTH: the PC after {WIDTH{1'b1}} & ~3 is 0.
- EPC:
  - On exc_req, epc <= exc_epc with bits [1:0] cleared.
  - Otherwise epc holds its value.
  - eret_req does not modify epc.
- ras_hit = ras_pop & !ras_empty & !exc_req & !eret_req & !redirect_valid.
- RAS storage:
  - RAS_DEPTH-entry circular buffer with a top pointer tp and a counter.
  - The top entry is mem[tp-1], with index arithmetic modulo RAS_DEPTH.
- RAS update gating:
  - exc_req or eret_req: RAS flushed (count <= 0); push and pop ignored.
  - Else stall with no redirect and no RAS hit: push and pop ignored; RAS unchanged.
  - Otherwise the RAS updates as below.
- RAS update:
  - Push only: mem[tp] <= addr; tp++; count = min(count+1, RAS_DEPTH). A push when full overwrites the oldest entry.
  - Pop only, when ras_hit: tp--; count--.
  - Pop when empty or blocked by a redirect: no change to the RAS.
  - Push and pop together with ras_hit: mem[tp-1] <= addr; tp and count unchanged. The next PC uses the old top.
  - Push together with redirect_valid (jal): the push takes effect; the pop is ignored.
- ras_full and ras_empty are decoded from the registered count.

## Timing
- Reset, asynchronous: pc = RESET_PC, epc = 0, count = 0, tp = 0. RAS contents are don't-care. ras_hit follows its inputs combinationally.
- Reset asserted mid-operation forces these values immediately, independent of clk.
- After reset deassertion, the first rising edge loads pc + 4 (or a higher-priority source).
- pc latency: one cycle. Inputs sampled at edge N appear on pc after edge N.
- ras_hit: zero latency, valid in the same cycle as ras_pop.
- No handshake. Every request is a single-cycle pulse and is consumed on the edge where it is sampled. Requests held for k cycles act k times.
- exc_req and eret_req in the same cycle: the exception wins, epc is updated and the RAS is flushed.

## Test plan
- Reset and sequential fetch: assert reset, release, run 3 clocks → pc = 0x3000 during reset, then 0x3004, 0x3008, 0x300C; epc = 0; ras_empty = 1.
- Stall versus redirect priority:
  - At pc = 0x3010, stall = 1 for 2 cycles → pc holds 0x3010.
  - Then stall = 1 with redirect_valid = 1 and redirect_pc = 0x3102 → pc = 0x3100.
- Exception and return:
  - exc_req with exc_epc = 0x3020 → pc = 0x4180 and epc = 0x3020.
  - With exc_req and eret_req together → exception wins.
  - Later eret_req → pc = 0x3020; ras_count = 0.
- RAS fill and overflow with RAS_DEPTH = 4:
  - Push 0x3100, 0x3200, 0x3300, 0x3400, 0x3500 → ras_count saturates at 4, ras_full = 1.
  - Then 4 pops → pc sequence 0x3500, 0x3400, 0x3300, 0x3200, with ras_hit = 1 on each.
  - A fifth pop → ras_hit = 0 and pc = previous + 4.
- Simultaneous push and pop:
  - With top 0x3200 and count 2, assert push 0x3800 and pop together → next pc = 0x3200; count stays 2; the next pop predicts 0x3800.
  - Pop together with redirect_valid → redirect taken, ras_hit = 0, count unchanged.
- Wrap and async reset:
  - Force pc to 0xFFFF_FFFC and increment → pc = 0x0000_0000.
  - Assert reset between clock edges → pc = 0x3000 immediately, before the next edge.
